seq_feed_ctrl: RTL and testbench
================================

// Module: seq_feed_ctrl
// PURPOSE
//  Controller that drives the Basys3 sequence-detector FSM from a latched test pattern.
//  On start it clears the detector, then shifts the pattern out MSB-first, one bit per step.
//  It emits a one-cycle step enable per bit and counts the detector's seq_det responses.
//  It reports busy/done, so one switch-set pattern is replayed at a human-visible rate.
// PARAMETERS
//  NBITS    16           pattern length in bits (>=2)
//  TICK_DIV 100_000_000  fsm_clk cycles per bit period (1 s at 100 MHz); must be > DET_LAT
//  DET_LAT  2            fsm_clk cycles from a step pulse to a valid det_in sample (>=1)
//  CNT_W    4            width of the detection counter
// PORTS
//  fsm_clk   in  1         system clock
//  clr       in  1         asynchronous active-high reset
//  start     in  1         one-cycle request (already debounced/edge-detected upstream)
//  pattern   in  NBITS     bit pattern to feed; latched on accepted start
//  det_in    in  1         seq_det from the detector
//  det_clr   out 1         synchronous clear pulse to the detector
//  din_out   out 1         current pattern bit to the detector din
//  step      out 1         one-cycle advance enable for the detector
//  busy      out 1         high from accepted start until done
//  done      out 1         one-cycle pulse at end of a run
//  det_count out CNT_W     detections in the current/last run, saturating
//  bit_idx   out clog2(NBITS+1)  bits already stepped in this run (0..NBITS)
// BEHAVIOUR
//  Reset (clr high, async): state IDLE; det_clr=0, din_out=0, step=0, busy=0, done=0,
//   det_count=0, bit_idx=0, tick counter=0, sample delay counter idle. Reset mid-run aborts the run.
//  States: IDLE -> CLR -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches pattern into a shift reg, zeroes det_count and bit_idx, and sets busy=1.
//   It then goes to CLR.
//  CLR: one cycle with det_clr=1; din_out loaded with latched MSB; go FEED, tick counter=0.
//  FEED: tick counter counts 0..TICK_DIV-1; at TICK_DIV-1 step=1 for that cycle only.
//   In the same cycle bit_idx increments, the counter wraps to 0, and the sample delay counter arms with DET_LAT.
//   din_out is stable over the whole bit period including the step cycle.
//   It changes to the next bit the cycle after step.
//   After the NBITS-th step go DRAIN; din_out then holds the last bit.
//  Sampling: exactly DET_LAT cycles after each step cycle, det_in is sampled.
//   If it is 1, det_count increments, saturating at 2^CNT_W-1 (no wrap).
//   A level held high across samples counts once per sample.
//  DRAIN: wait until the final step's sample cycle has been taken (DET_LAT cycles), then go DONE.
//  DONE: done=1 for one cycle with busy still 1; next cycle IDLE with busy=0.
//   det_count and bit_idx hold until the next accepted start.
//  start while busy (CLR/FEED/DRAIN/DONE) is ignored; no queueing.
//  start in the IDLE cycle right after DONE is accepted normally.
//  pattern changes while busy have no effect; only the latched copy is fed.
//  step and det_clr are never high in the same cycle; step is never high outside FEED.
// TESTING (bench params NBITS=8, TICK_DIV=4, DET_LAT=2; behavioural detector model on det_in)
//  1. Reset: assert clr -> all outputs 0.
//     Pulse start with pattern=8'hA5 -> det_clr=1 one cycle after start.
//     Then 8 step pulses, 4 cycles apart.
//     din_out during each step = 1,0,1,0,0,1,0,1.
//  2. Model asserts det_in for 1 cycle exactly DET_LAT after steps 4 and 8 -> det_count=2 at done.
//     done pulse is 1 cycle wide, occurring DET_LAT+1 cycles after step 8; busy falls the next cycle.
//  3. Tie det_in=1, CNT_W=2 -> det_count saturates at 3, no wrap to 0.
//  4. Pulse start mid-FEED with a different pattern -> ignored.
//     Fed bits and step count are unchanged; bit_idx reaches 8.
//  5. Assert clr asynchronously between steps 3 and 4 -> outputs 0 immediately.
//     No further step; a new start afterwards runs all 8 bits from MSB.
//  6. Pulse start on the first IDLE cycle after done -> new run accepted.
//     det_count resets to 0, then counts afresh.

Source files
------------

// File: rtl/seq_feed_ctrl.sv
// seq_feed_ctrl: replays a latched bit pattern into the sequence-detector FSM.
// A run clears the detector, then steps the pattern out MSB-first, one bit per
// tick period. It counts detector hits sampled a fixed latency after each step
// and reports busy/done.
module seq_feed_ctrl #(
  parameter int NBITS    = 16,
  parameter int TICK_DIV = 100_000_000,
  parameter int DET_LAT  = 2,
  parameter int CNT_W    = 4
) (
  input  logic                         fsm_clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic [NBITS-1:0]             pattern,
  input  logic                         det_in,
  output logic                         det_clr,
  output logic                         din_out,
  output logic                         step,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             det_count,
  output logic [$clog2(NBITS+1)-1:0]   bit_idx
);

  localparam int IDX_W  = $clog2(NBITS+1);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DLY_W  = $clog2(DET_LAT+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [TICK_W-1:0]  tick;
  logic [DLY_W-1:0]   dly;
  logic [NBITS-1:0]   shreg;
  logic               tick_end;
  logic               last_bit;
  logic               sample;
  logic               accept;

  // Detection counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign tick_end = (tick == TICK_W'(TICK_DIV - 1));
  assign last_bit = (bit_idx == IDX_W'(NBITS - 1));
  // dly counts DET_LAT..1 after a step; the cycle at 1 is the sample cycle.
  assign sample   = (dly == DLY_W'(1));
  assign accept   = (state == S_IDLE) && start;

  // State register; a reset in the middle of a run drops straight back to idle.
  always_ff @(posedge fsm_clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the per-state strobes (det_clr, step, busy, done).
  always_comb begin
    state_nxt = state;
    det_clr   = 1'b0;
    step      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLR;
      end
      S_CLR: begin
        det_clr   = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        if (tick_end) begin
          step = 1'b1;
          if (last_bit) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sample) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit-period timer, sample delay, step index, detection count and din drive.
  always_ff @(posedge fsm_clk or posedge clr) begin
    if (clr) begin
      tick      <= '0;
      dly       <= '0;
      bit_idx   <= '0;
      det_count <= '0;
      din_out   <= 1'b0;
    end else begin
      if (state == S_CLR)       tick <= '0;
      else if (state == S_FEED) tick <= tick_end ? '0 : tick + TICK_W'(1);

      if (step)            dly <= DLY_W'(DET_LAT);
      else if (dly != '0)  dly <= dly - DLY_W'(1);

      if (accept)    bit_idx <= '0;
      else if (step) bit_idx <= bit_idx + IDX_W'(1);

      if (accept)                det_count <= '0;
      else if (sample && det_in) det_count <= sat_inc(det_count);

      // The last bit is left on din_out through drain and idle.
      if (state == S_CLR || (step && !last_bit)) din_out <= shreg[NBITS-1];
    end
  end

  // Pattern shift register: loaded on an accepted start, shifted as bits go out.
  always_ff @(posedge fsm_clk) begin
    if (accept)                                 shreg <= pattern;
    else if (state == S_CLR || (step && !last_bit)) shreg <= shreg << 1;
  end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// tb_seq_feed_ctrl: directed bench for seq_feed_ctrl with NBITS=8, TICK_DIV=4,
// DET_LAT=2. A small behavioural detector raises det_in for one cycle DET_LAT
// after selected steps. A second instance with CNT_W=2 and det_in tied high
// covers counter saturation.
module tb_seq_feed_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] pattern;
  logic       det_in;
  logic       det_clr, din_out, step, busy, done;
  logic [3:0] det_count;
  logic [3:0] bit_idx;

  logic       start_s;
  logic [7:0] pattern_s;
  logic       det_clr_s, din_out_s, step_s, busy_s, done_s;
  logic [1:0] det_count_s;
  logic [3:0] bit_idx_s;

  int checks = 0;
  int errors = 0;

  // Detector model: det_mask bit k fires for step k+1 of the run.
  logic [7:0] det_mask;
  logic [2:0] m_cnt;
  logic       det_p1, det_p2;

  seq_feed_ctrl #(.NBITS(8), .TICK_DIV(4), .DET_LAT(2), .CNT_W(4)) dut (
    .fsm_clk(clk), .clr(clr), .start(start), .pattern(pattern), .det_in(det_in),
    .det_clr(det_clr), .din_out(din_out), .step(step), .busy(busy), .done(done),
    .det_count(det_count), .bit_idx(bit_idx)
  );

  seq_feed_ctrl #(.NBITS(8), .TICK_DIV(4), .DET_LAT(2), .CNT_W(2)) dut_sat (
    .fsm_clk(clk), .clr(clr), .start(start_s), .pattern(pattern_s), .det_in(1'b1),
    .det_clr(det_clr_s), .din_out(din_out_s), .step(step_s), .busy(busy_s), .done(done_s),
    .det_count(det_count_s), .bit_idx(bit_idx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_cnt  <= '0;
      det_p1 <= 1'b0;
      det_p2 <= 1'b0;
    end else begin
      det_p2 <= det_p1;
      det_p1 <= 1'b0;
      if (det_clr) m_cnt <= '0;
      if (step) begin
        m_cnt  <= m_cnt + 3'd1;
        det_p1 <= det_mask[m_cnt];
      end
    end
  end
  assign det_in = det_p2;

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  // Advance until step is seen (max 8 cycles); lat is the cycles taken.
  task automatic wait_step(output int lat);
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      nc();
      lat++;
      if (step) break;
    end
  endtask

  // From the CLR cycle, gather din_out at each step until done. Optionally
  // pulses start with inj_pat at cycle inj_cyc.
  task automatic collect(input int inj_cyc, input logic [7:0] inj_pat,
                         output logic [7:0] bits, output int nsteps,
                         output int bad_gap, output bit got_done);
    int gap;
    bits = '0; nsteps = 0; bad_gap = 0; got_done = 1'b0; gap = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == inj_cyc) begin start = 1'b1; pattern = inj_pat; end
      nc();
      if (c == inj_cyc) start = 1'b0;
      gap++;
      if (step) begin
        bits = {bits[6:0], din_out};
        nsteps++;
        if (gap != 4) bad_gap++;
        gap = 0;
      end
      if (done) begin got_done = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [12:0] v;
    logic [10:0] vs;
    clr = 1'b1;
    nc(); nc();
    v  = {det_clr, din_out, step, busy, done, det_count, bit_idx};
    vs = {det_clr_s, din_out_s, step_s, busy_s, done_s, det_count_s, bit_idx_s};
    checks++;
    if (v !== 13'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
    checks++;
    if (vs !== 11'd0) begin errors++; $display("FAIL reset_outputs_sat: got %h expected 0", vs); end
    clr = 1'b0;
    nc(); nc(); nc(); nc(); nc();
    checks++;
    if ({step, busy, det_clr} !== 3'b000) begin
      errors++; $display("FAIL idle_quiet: got %b expected 000", {step, busy, det_clr});
    end
  endtask

  task automatic test_feed();
    logic [7:0] exp_bits;
    int lat;
    int bad_lat, bad_din, bad_idx;
    exp_bits = 8'hA5;
    det_mask = 8'h88;
    bad_lat = 0; bad_din = 0; bad_idx = 0;
    nc();
    start = 1'b1; pattern = 8'hA5;
    nc();
    start = 1'b0;
    checks++;
    if ({det_clr, step, busy} !== 3'b101) begin
      errors++; $display("FAIL clr_cycle: got %b expected 101", {det_clr, step, busy});
    end
    for (int k = 0; k < 8; k++) begin
      wait_step(lat);
      if (lat != 4 || !step) bad_lat++;
      if (din_out !== exp_bits[7-k]) bad_din++;
      if (bit_idx !== 4'(k)) bad_idx++;
    end
    checks++;
    if (bad_lat != 0) begin errors++; $display("FAIL step_spacing: got %0d bad steps expected 0", bad_lat); end
    checks++;
    if (bad_din != 0) begin errors++; $display("FAIL din_at_step: got %0d wrong bits expected 0", bad_din); end
    checks++;
    if (bad_idx != 0) begin errors++; $display("FAIL bit_idx_at_step: got %0d wrong expected 0", bad_idx); end
    nc();
    nc();
    checks++;
    if ({done, busy, din_out} !== 3'b011) begin
      errors++; $display("FAIL drain: got %b expected 011", {done, busy, din_out});
    end
    nc();
    checks++;
    if ({done, busy} !== 2'b11) begin errors++; $display("FAIL done_pulse: got %b expected 11", {done, busy}); end
    checks++;
    if (det_count !== 4'd2) begin errors++; $display("FAIL det_count_done: got %0d expected 2", det_count); end
    checks++;
    if (bit_idx !== 4'd8) begin errors++; $display("FAIL bit_idx_done: got %0d expected 8", bit_idx); end
    nc();
    checks++;
    if ({done, busy, det_count} !== 6'b00_0010) begin
      errors++; $display("FAIL after_done: got %b expected 000010", {done, busy, det_count});
    end
  endtask

  task automatic test_saturate();
    int dec;
    bit got;
    logic [1:0] prev;
    dec = 0; got = 1'b0; prev = '0;
    nc();
    start_s = 1'b1; pattern_s = 8'hFF;
    nc();
    start_s = 1'b0;
    for (int c = 0; c < 100; c++) begin
      nc();
      if (det_count_s < prev) dec++;
      prev = det_count_s;
      if (done_s) begin got = 1'b1; break; end
    end
    checks++;
    if ({got, busy_s} !== 2'b11) begin errors++; $display("FAIL sat_done: got %b expected 11", {got, busy_s}); end
    checks++;
    if (det_count_s !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", det_count_s); end
    checks++;
    if (dec != 0) begin errors++; $display("FAIL sat_no_wrap: got %0d decreases expected 0", dec); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] bits;
    int nsteps, bad_gap;
    bit got_done;
    int late;
    det_mask = 8'h00;
    nc();
    start = 1'b1; pattern = 8'hC3;
    nc();
    start = 1'b0;
    collect(10, 8'h5A, bits, nsteps, bad_gap, got_done);
    checks++;
    if (bits !== 8'hC3) begin errors++; $display("FAIL ignore_bits: got %h expected c3", bits); end
    checks++;
    if ({got_done, nsteps[3:0], bad_gap[3:0]} !== {1'b1, 4'd8, 4'd0}) begin
      errors++; $display("FAIL ignore_steps: done %0d steps %0d badgap %0d expected 1 8 0", got_done, nsteps, bad_gap);
    end
    checks++;
    if (bit_idx !== 4'd8) begin errors++; $display("FAIL ignore_bit_idx: got %0d expected 8", bit_idx); end
    late = 0;
    for (int c = 0; c < 6; c++) begin
      nc();
      if (busy || det_clr) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL ignore_no_queue: got %0d busy cycles expected 0", late); end
  endtask

  task automatic test_abort();
    logic [7:0] bits;
    int nsteps, bad_gap, seen, stray;
    bit got_done;
    logic [12:0] v;
    det_mask = 8'h00;
    seen = 0;
    nc();
    start = 1'b1; pattern = 8'h96;
    nc();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      nc();
      if (step) seen++;
      if (seen == 3) break;
    end
    nc();
    checks++;
    if ({seen[3:0], busy, din_out} !== {4'd3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL abort_pre: steps %0d busy %b din %b expected 3 1 1", seen, busy, din_out);
    end
    #2 clr = 1'b1;
    #1;
    v = {det_clr, din_out, step, busy, done, det_count, bit_idx};
    checks++;
    if (v !== 13'd0) begin errors++; $display("FAIL abort_async: got %h expected 0", v); end
    @(posedge clk);
    #3 clr = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      nc();
      if (step || busy) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL abort_no_step: got %0d active cycles expected 0", stray); end
    start = 1'b1; pattern = 8'h96;
    nc();
    start = 1'b0;
    collect(-1, 8'h00, bits, nsteps, bad_gap, got_done);
    checks++;
    if ({bits, got_done, nsteps[3:0]} !== {8'h96, 1'b1, 4'd8}) begin
      errors++; $display("FAIL abort_rerun: bits %h done %0d steps %0d expected 96 1 8", bits, got_done, nsteps);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    int nsteps, bad_gap;
    bit got_done;
    det_mask = 8'h88;
    nc();
    start = 1'b1; pattern = 8'hA5;
    nc();
    start = 1'b0;
    collect(-1, 8'h00, bits, nsteps, bad_gap, got_done);
    checks++;
    if ({got_done, det_count} !== {1'b1, 4'd2}) begin
      errors++; $display("FAIL b2b_first: done %0d count %0d expected 1 2", got_done, det_count);
    end
    nc();
    det_mask = 8'h01;
    start = 1'b1; pattern = 8'h3C;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b expected 0", busy); end
    nc();
    start = 1'b0;
    checks++;
    if ({det_clr, busy, det_count, bit_idx} !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      errors++; $display("FAIL b2b_accept: clr %b busy %b count %0d idx %0d expected 1 1 0 0", det_clr, busy, det_count, bit_idx);
    end
    collect(-1, 8'h00, bits, nsteps, bad_gap, got_done);
    checks++;
    if ({bits, got_done, bad_gap[3:0]} !== {8'h3C, 1'b1, 4'd0}) begin
      errors++; $display("FAIL b2b_bits: bits %h done %0d badgap %0d expected 3c 1 0", bits, got_done, bad_gap);
    end
    checks++;
    if (det_count !== 4'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", det_count); end
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b0;
    pattern = '0;
    start_s = 1'b0;
    pattern_s = '0;
    det_mask = '0;
    test_reset();
    test_feed();
    test_saturate();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
